// File: rtl/program_loader.sv
// program_loader
//   Pulls a length-prefixed program image out of the UART receive buffer one
//   byte at a time, packs it into DATA_WIDTH-bit words and writes them to
//   instruction memory through a valid/ready handshake. load_completed
//   releases the rest of the system; load_error flags a bad header or an
//   inter-byte timeout. Both flags are sticky until reset.
//
//   Ports
//     clk             clock
//     reset           asynchronous reset, active low
//     uart_buf_len    bytes waiting in the UART receive buffer
//     uart_out_valid  byte read request
//     uart_out_data   byte returned, valid while uart_out_ready=1
//     uart_out_ready  read acknowledge
//     mem_in_addr     write byte address
//     mem_in_data     write data
//     mem_in_valid    write request
//     mem_in_ready    write acknowledge
//     load_completed  image fully written (sticky)
//     load_error      bad length or timeout (sticky)
//     word_count      words written so far
module program_loader #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter bit          BIG_ENDIAN     = 1'b0,
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter int unsigned MAX_WORDS      = 16384,
   parameter int unsigned BUF_LEN_WIDTH  = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BUF_LEN_WIDTH-1:0] uart_buf_len,
   output logic                     uart_out_valid,
   input  logic [7:0]               uart_out_data,
   input  logic                     uart_out_ready,
   output logic [31:0]              mem_in_addr,
   output logic [DATA_WIDTH-1:0]    mem_in_data,
   output logic                     mem_in_valid,
   input  logic                     mem_in_ready,
   output logic                     load_completed,
   output logic                     load_error,
   output logic [31:0]              word_count
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      HEADER,
      PAYLOAD,
      WRITE,
      DONE,
      ERROR
   } state_t;

   state_t                state;
   logic [3:0]            byte_idx;
   logic [31:0]           hdr;
   logic [DATA_WIDTH-1:0] word_reg;
   logic [31:0]           tmo_cnt;
   logic                  started;

   logic [31:0]           hdr_next;
   logic [DATA_WIDTH-1:0] word_next;
   logic                  byte_take;
   logic                  tmo_hit;

   // Shift-based packing keeps DATA_WIDTH=8 legal (no negative slices).
   always_comb begin
      hdr_next  = '0;
      word_next = '0;
      if (BIG_ENDIAN) begin
         hdr_next  = (hdr << 8) | 32'(uart_out_data);
         word_next = (word_reg << 8) | DATA_WIDTH'(uart_out_data);
      end else begin
         hdr_next  = (hdr >> 8) | (32'(uart_out_data) << 24);
         word_next = (word_reg >> 8) | (DATA_WIDTH'(uart_out_data) << (DATA_WIDTH - 8));
      end
   end

   assign byte_take = uart_out_valid && uart_out_ready;
   assign tmo_hit   = (TIMEOUT_CYCLES != 0) && started &&
                      (tmo_cnt == TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= HEADER;
         byte_idx       <= '0;
         hdr            <= '0;
         word_reg       <= '0;
         tmo_cnt        <= '0;
         started        <= 1'b0;
         uart_out_valid <= 1'b0;
         mem_in_addr    <= '0;
         mem_in_data    <= '0;
         mem_in_valid   <= 1'b0;
         load_completed <= 1'b0;
         load_error     <= 1'b0;
         word_count     <= '0;
      end else begin
         case (state)
            HEADER, PAYLOAD: begin
               // A captured byte outranks a timeout expiring on the same edge.
               if (byte_take) begin
                  uart_out_valid <= 1'b0;
                  tmo_cnt        <= '0;
                  started        <= 1'b1;
                  if (state == HEADER) begin
                     hdr <= hdr_next;
                     if (byte_idx == 4'd3) begin
                        byte_idx <= '0;
                        if (hdr_next > 32'(MAX_WORDS)) begin
                           state      <= ERROR;
                           load_error <= 1'b1;
                        end else if (hdr_next == '0) begin
                           state          <= DONE;
                           load_completed <= 1'b1;
                        end else begin
                           state <= PAYLOAD;
                        end
                     end else begin
                        byte_idx <= byte_idx + 4'd1;
                     end
                  end else begin
                     word_reg <= word_next;
                     if (byte_idx == 4'(BYTES - 1)) begin
                        byte_idx     <= '0;
                        state        <= WRITE;
                        mem_in_valid <= 1'b1;
                        mem_in_addr  <= BASE_ADDR + word_count * 32'(BYTES);
                        mem_in_data  <= word_next;
                     end else begin
                        byte_idx <= byte_idx + 4'd1;
                     end
                  end
               end else if (tmo_hit) begin
                  state          <= ERROR;
                  load_error     <= 1'b1;
                  uart_out_valid <= 1'b0;
               end else begin
                  if (started && (TIMEOUT_CYCLES != 0))
                     tmo_cnt <= tmo_cnt + 32'd1;
                  // Valid is low for at least the cycle after each capture.
                  if (!uart_out_valid && (uart_buf_len != '0))
                     uart_out_valid <= 1'b1;
               end
            end

            WRITE: begin
               if (mem_in_valid && mem_in_ready) begin
                  mem_in_valid <= 1'b0;
                  word_count   <= word_count + 32'd1;
                  if (word_count + 32'd1 == hdr) begin
                     state          <= DONE;
                     load_completed <= 1'b1;
                  end else begin
                     state <= PAYLOAD;
                  end
               end
            end

            DONE: begin
               load_completed <= 1'b1;
            end

            ERROR: begin
               load_error     <= 1'b1;
               load_completed <= 1'b0;
               uart_out_valid <= 1'b0;
               mem_in_valid   <= 1'b0;
            end

            default: state <= ERROR;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sel = 1'b0;
   logic       rdy = 1'b0;
   logic       mem_rdy = 1'b1;
   logic [7:0] dat = '0;
   logic [9:0] len = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Instance A: little-endian, base 0, MAX_WORDS=4, timeout 50
   logic [9:0]  ulen_a;
   logic        urdy_a, uv_a, mv_a, done_a, err_a;
   logic [31:0] addr_a, data_a, wc_a;
   // Instance B: big-endian, base 0x100, timeout disabled
   logic [9:0]  ulen_b;
   logic        urdy_b, uv_b, mv_b, done_b, err_b;
   logic [31:0] addr_b, data_b, wc_b;

   assign ulen_a = sel ? 10'd0 : len;
   assign ulen_b = sel ? len : 10'd0;
   assign urdy_a = !sel && rdy;
   assign urdy_b = sel && rdy;

   program_loader #(
      .DATA_WIDTH(32), .BIG_ENDIAN(1'b0), .BASE_ADDR(32'h0),
      .MAX_WORDS(4), .BUF_LEN_WIDTH(10), .TIMEOUT_CYCLES(50)
   ) dut_a (
      .clk(clk), .reset(rst), .uart_buf_len(ulen_a), .uart_out_valid(uv_a),
      .uart_out_data(dat), .uart_out_ready(urdy_a), .mem_in_addr(addr_a),
      .mem_in_data(data_a), .mem_in_valid(mv_a), .mem_in_ready(mem_rdy),
      .load_completed(done_a), .load_error(err_a), .word_count(wc_a)
   );

   program_loader #(
      .DATA_WIDTH(32), .BIG_ENDIAN(1'b1), .BASE_ADDR(32'h100),
      .MAX_WORDS(16384), .BUF_LEN_WIDTH(10), .TIMEOUT_CYCLES(0)
   ) dut_b (
      .clk(clk), .reset(rst), .uart_buf_len(ulen_b), .uart_out_valid(uv_b),
      .uart_out_data(dat), .uart_out_ready(urdy_b), .mem_in_addr(addr_b),
      .mem_in_data(data_b), .mem_in_valid(mv_b), .mem_in_ready(mem_rdy),
      .load_completed(done_b), .load_error(err_b), .word_count(wc_b)
   );

   logic        uv_s, mv_s, done_s, err_s;
   logic [31:0] addr_s, data_s, wc_s;
   assign uv_s   = sel ? uv_b   : uv_a;
   assign mv_s   = sel ? mv_b   : mv_a;
   assign done_s = sel ? done_b : done_a;
   assign err_s  = sel ? err_b  : err_a;
   assign addr_s = sel ? addr_b : addr_a;
   assign data_s = sel ? data_b : data_a;
   assign wc_s   = sel ? wc_b   : wc_a;

   // Write logs
   int          wr_cnt_a = 0;
   int          wr_cnt_b = 0;
   logic [31:0] alog_a [64];
   logic [31:0] dlog_a [64];
   logic [31:0] alog_b [64];
   logic [31:0] dlog_b [64];

   always @(posedge clk) begin
      if (mv_a && mem_rdy) begin
         alog_a[wr_cnt_a % 64] <= addr_a;
         dlog_a[wr_cnt_a % 64] <= data_a;
         wr_cnt_a <= wr_cnt_a + 1;
      end
   end

   always @(posedge clk) begin
      if (mv_b && mem_rdy) begin
         alog_b[wr_cnt_b % 64] <= addr_b;
         dlog_b[wr_cnt_b % 64] <= data_b;
         wr_cnt_b <= wr_cnt_b + 1;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      rdy = 1'b0;
      len = '0;
      mem_rdy = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outputs", {uv_s, mv_s, addr_s, data_s, done_s, err_s, wc_s}, '0);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Serves n bytes, first byte taken from the left of the n-byte stream.
   task automatic feed(input logic [159:0] stream, input int n);
      logic [159:0] al;
      int w;
      al  = stream << (160 - 8 * n);
      len = 10'(n);
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (!uv_s && w < 100) begin
            @(negedge clk);
            w++;
         end
         checks++;
         if (!uv_s) begin
            errors++;
            $display("FAIL byte_req: byte %0d got no uart_out_valid, required 1", i);
            len = '0;
            return;
         end
         dat = al[159 - 8 * i -: 8];
         rdy = 1'b1;
         len = 10'(n - i - 1);
         @(negedge clk);
         rdy = 1'b0;
      end
   endtask

   typedef struct packed {
      logic [159:0] stream;
      int unsigned  n;
      logic         exp_done;
      logic         exp_err;
      logic [31:0]  exp_wc;
      int unsigned  exp_nwr;
      logic [31:0]  fa;
      logic [31:0]  fd;
      logic [31:0]  la;
      logic [31:0]  ld;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int base, lat, nwr;
      logic seen_uv;

      vecs[0] = '{stream: 160'h02000000_13000000_93001000, n: 12, exp_done: 1'b1, exp_err: 1'b0,
                  exp_wc: 32'd2, exp_nwr: 2, fa: 32'h0, fd: 32'h00000013, la: 32'h4, ld: 32'h00100093};
      vecs[1] = '{stream: 160'h00000000, n: 4, exp_done: 1'b1, exp_err: 1'b0,
                  exp_wc: 32'd0, exp_nwr: 0, fa: 32'h0, fd: 32'h0, la: 32'h0, ld: 32'h0};
      vecs[2] = '{stream: 160'h05000000, n: 4, exp_done: 1'b0, exp_err: 1'b1,
                  exp_wc: 32'd0, exp_nwr: 0, fa: 32'h0, fd: 32'h0, la: 32'h0, ld: 32'h0};
      vecs[3] = '{stream: 160'h04000000_01000000_02000000_03000000_04000000, n: 20, exp_done: 1'b1,
                  exp_err: 1'b0, exp_wc: 32'd4, exp_nwr: 4, fa: 32'h0, fd: 32'h1, la: 32'hC, ld: 32'h4};
      vecs[4] = '{stream: 160'h01000000_AABBCCDD, n: 8, exp_done: 1'b1, exp_err: 1'b0,
                  exp_wc: 32'd1, exp_nwr: 1, fa: 32'h0, fd: 32'hDDCCBBAA, la: 32'h0, ld: 32'hDDCCBBAA};

      sel = 1'b0;
      for (int v = 0; v < 5; v++) begin
         do_reset();
         base = wr_cnt_a;
         feed(vecs[v].stream, int'(vecs[v].n));
         lat = 0;
         while (!(done_s || err_s) && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         if (vecs[v].exp_done || vecs[v].exp_err)
            check("end_latency", 128'(lat < 10), 128'(1));
         repeat (3) @(negedge clk);
         check("load_completed", 128'(done_s), 128'(vecs[v].exp_done));
         check("load_error", 128'(err_s), 128'(vecs[v].exp_err));
         check("word_count", 128'(wc_s), 128'(vecs[v].exp_wc));
         nwr = wr_cnt_a - base;
         check("write_count", 128'(nwr), 128'(vecs[v].exp_nwr));
         if (vecs[v].exp_nwr != 0 && nwr == int'(vecs[v].exp_nwr)) begin
            check("first_write", {alog_a[base % 64], dlog_a[base % 64]},
                  {vecs[v].fa, vecs[v].fd});
            check("last_write", {alog_a[(base + nwr - 1) % 64], dlog_a[(base + nwr - 1) % 64]},
                  {vecs[v].la, vecs[v].ld});
         end
      end

      // Memory back-pressure: request must stay frozen, no UART reads meanwhile
      do_reset();
      base = wr_cnt_a;
      mem_rdy = 1'b0;
      feed(160'h01000000_78563412, 8);
      len = 10'd3;
      for (int i = 0; i < 7; i++) begin
         check("hold_stable", {uv_s, mv_s, addr_s, data_s}, {1'b0, 1'b1, 32'h0, 32'h12345678});
         @(negedge clk);
      end
      mem_rdy = 1'b1;
      @(negedge clk);
      check("hold_writes", 128'(wr_cnt_a - base), 128'(1));
      check("hold_done", {done_s, err_s, wc_s}, {1'b1, 1'b0, 32'd1});
      seen_uv = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen_uv = seen_uv | uv_s;
      end
      check("done_no_reads", 128'(seen_uv), 128'(0));

      // Timeout: error exactly 50 cycles after last captured byte
      do_reset();
      feed(160'h02000000_1122, 6);
      repeat (49) @(negedge clk);
      check("tmo_before", 128'(err_s), 128'(0));
      @(negedge clk);
      check("tmo_at_50", {err_s, done_s, wc_s, uv_s, mv_s}, {1'b1, 1'b0, 32'd0, 1'b0, 1'b0});

      // Byte arriving on the expiry cycle wins
      do_reset();
      base = wr_cnt_a;
      feed(160'h02000000_1122, 6);
      len = 10'd1;
      repeat (49) @(negedge clk);
      check("tmo_req_pending", 128'(uv_s), 128'(1));
      dat = 8'h33;
      rdy = 1'b1;
      len = 10'd0;
      @(negedge clk);
      rdy = 1'b0;
      check("tmo_byte_wins", 128'(err_s), 128'(0));
      repeat (10) @(negedge clk);
      feed(160'h44, 1);
      repeat (3) @(negedge clk);
      check("tmo_resume", {err_s, wc_s}, {1'b0, 32'd1});
      check("tmo_resume_write", {alog_a[base % 64], dlog_a[base % 64]}, {32'h0, 32'h44332211});

      // Instance B: big-endian, base 0x100, timeout disabled
      sel = 1'b1;
      do_reset();
      base = wr_cnt_b;
      feed(160'h00000002_DEADBEEF, 8);
      repeat (200) @(negedge clk);
      check("be_no_timeout", {err_s, done_s, wc_s}, {1'b0, 1'b0, 32'd1});
      check("be_write0", {alog_b[base % 64], dlog_b[base % 64]}, {32'h100, 32'hDEADBEEF});
      feed(160'h01020304, 4);
      repeat (3) @(negedge clk);
      check("be_done", {err_s, done_s, wc_s}, {1'b0, 1'b1, 32'd2});
      check("be_write1", {alog_b[(base + 1) % 64], dlog_b[(base + 1) % 64]}, {32'h104, 32'h01020304});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
